// File: rtl/ipg_rresp_gen.sv
// ipg_rresp_gen: transmit-side read-response framer for the IPG channel.
// Accepts one read response (address, bit length, payload) and serialises it
// into the variable-size IPG slots offered by the PHY TX path: one header
// chunk {len, addr, zero pad}, then MSB-first payload chunks.
//
// Ports:
//   clk          clock
//   reset        asynchronous, active-high reset
//   req_valid    response request valid
//   req_ready    block can accept a request (combinational, state==IDLE)
//   req_addr     read address being answered
//   req_len      payload length in bits, legal 1..PAYLOAD_LEN
//   req_payload  payload right-aligned in [req_len-1:0], bit req_len-1 sent first
//   tx_space     bits the PHY can carry in the current slot, 0 = no slot
//   tx_ipg_data  chunk, MSB-aligned (registered)
//   tx_len       valid bits in tx_ipg_data (registered)
//   rresp_valid  one-cycle pulse per chunk
//   req_err      one-cycle pulse: request rejected for illegal length
//   done         one-cycle pulse coincident with the last chunk
module ipg_rresp_gen #(
   parameter int DATA_WIDTH  = 64,
   parameter int HDR_WIDTH   = 16,
   parameter int ADR_WIDTH   = 12,
   parameter int PAYLOAD_LEN = 512
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   req_valid,
   output logic                   req_ready,
   input  logic [ADR_WIDTH-1:0]   req_addr,
   input  logic [HDR_WIDTH-1:0]   req_len,
   input  logic [PAYLOAD_LEN-1:0] req_payload,
   input  logic [5:0]             tx_space,
   output logic [DATA_WIDTH-1:0]  tx_ipg_data,
   output logic [5:0]             tx_len,
   output logic                   rresp_valid,
   output logic                   req_err,
   output logic                   done
);

   localparam int HDR_BITS = HDR_WIDTH + ADR_WIDTH;
   localparam int PAD_BITS = DATA_WIDTH - HDR_BITS;

   typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;

   state_t                 state_q, state_d;
   logic [ADR_WIDTH-1:0]   addr_q;
   logic [HDR_WIDTH-1:0]   len_q;
   logic [HDR_WIDTH-1:0]   rem_q, rem_d;
   logic [PAYLOAD_LEN-1:0] shreg_q, shreg_d;

   logic [DATA_WIDTH-1:0]  data_d;
   logic [5:0]             tlen_d;
   logic                   valid_d, done_d, err_d;

   logic                   accept, len_bad, hdr_fit, last;
   logic [HDR_WIDTH-1:0]   shamt, space_ext;
   logic [5:0]             n;

   always_comb begin
      req_ready = (state_q == IDLE);
      accept    = req_valid && req_ready;
      len_bad   = (req_len == '0) || (req_len > HDR_WIDTH'(PAYLOAD_LEN));
      shamt     = HDR_WIDTH'(PAYLOAD_LEN) - req_len;
      space_ext = HDR_WIDTH'(tx_space);
      // n = min(tx_space, rem); rem only drops below 64 when the low bits suffice
      n         = (space_ext < rem_q) ? tx_space : rem_q[5:0];
      hdr_fit   = (tx_space >= 6'(HDR_BITS));
      last      = (tx_space != '0) && (space_ext >= rem_q);
   end

   // state register, stored request and registered outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         len_q       <= '0;
         rem_q       <= '0;
         shreg_q     <= '0;
         tx_ipg_data <= '0;
         tx_len      <= '0;
         rresp_valid <= 1'b0;
         req_err     <= 1'b0;
         done        <= 1'b0;
      end else begin
         state_q     <= state_d;
         if (accept) begin
            addr_q <= req_addr;
            len_q  <= req_len;
         end
         rem_q       <= rem_d;
         shreg_q     <= shreg_d;
         tx_ipg_data <= data_d;
         tx_len      <= tlen_d;
         rresp_valid <= valid_d;
         req_err     <= err_d;
         done        <= done_d;
      end
   end

   // next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (accept && !len_bad) state_d = HDR;
         HDR:     if (hdr_fit)            state_d = DATA;
         DATA:    if (last)               state_d = IDLE;
         default:                         state_d = IDLE;
      endcase
   end

   // output and datapath logic
   always_comb begin
      data_d  = '0;
      tlen_d  = '0;
      valid_d = 1'b0;
      done_d  = 1'b0;
      err_d   = 1'b0;
      rem_d   = rem_q;
      shreg_d = shreg_q;
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               rem_d   = req_len;
               // Left-justify the payload so every chunk is simply the top bits
               // of the shift register; bits above req_len-1 fall off the top.
               shreg_d = req_payload << shamt;
               err_d   = len_bad;
            end
         end
         HDR: begin
            if (hdr_fit) begin
               data_d  = {len_q, addr_q, {PAD_BITS{1'b0}}};
               tlen_d  = 6'(HDR_BITS);
               valid_d = 1'b1;
            end
         end
         DATA: begin
            if (tx_space != '0) begin
               data_d  = shreg_q[PAYLOAD_LEN-1 -: DATA_WIDTH]
                         & ~({DATA_WIDTH{1'b1}} >> n);
               tlen_d  = n;
               valid_d = 1'b1;
               done_d  = last;
               rem_d   = rem_q - HDR_WIDTH'(n);
               shreg_d = shreg_q << n;
            end
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_ipg_rresp_gen.sv
// Self-checking bench for ipg_rresp_gen: directed scenarios plus a randomized
// run checked against a bit-level reference model of the chunking rules.
module tb_ipg_rresp_gen;

   localparam int DW = 64;
   localparam int HW = 16;
   localparam int AW = 12;
   localparam int PL = 512;

   logic          clk = 1'b0;
   logic          reset;
   logic          req_valid;
   logic          req_ready;
   logic [AW-1:0] req_addr;
   logic [HW-1:0] req_len;
   logic [PL-1:0] req_payload;
   logic [5:0]    tx_space;
   logic [DW-1:0] tx_ipg_data;
   logic [5:0]    tx_len;
   logic          rresp_valid;
   logic          req_err;
   logic          done;

   logic [72:0]   obs;
   assign obs = {rresp_valid, done, req_err, tx_len, tx_ipg_data};

   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;

   always #5 clk = ~clk;

   ipg_rresp_gen #(
      .DATA_WIDTH (DW),
      .HDR_WIDTH  (HW),
      .ADR_WIDTH  (AW),
      .PAYLOAD_LEN(PL)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_addr   (req_addr),
      .req_len    (req_len),
      .req_payload(req_payload),
      .tx_space   (tx_space),
      .tx_ipg_data(tx_ipg_data),
      .tx_len     (tx_len),
      .rresp_valid(rresp_valid),
      .req_err    (req_err),
      .done       (done)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      req_valid   = 1'b0;
      req_addr    = '0;
      req_len     = '0;
      req_payload = '0;
      tx_space    = '0;
   endtask

   function automatic logic [PL-1:0] rand_payload();
      logic [PL-1:0] p;
      for (int i = 0; i < PL / 32; i++) p[i*32 +: 32] = $urandom;
      return p;
   endfunction

   // chunk bit k (from the MSB) carries payload bit len-1-sent-k
   function automatic logic [DW-1:0] exp_chunk(input logic [PL-1:0] p, input int len,
                                                input int sent, input int n);
      logic [DW-1:0] c = '0;
      for (int k = 0; k < n; k++) c[DW-1-k] = p[len-1-sent-k];
      return c;
   endfunction

   function automatic logic [PL-1:0] len_mask(input int len);
      return {PL{1'b1}} >> (PL - len);
   endfunction

   task automatic test_reset();
      reset = 1'b1;
      idle_inputs();
      #12;
      n_cmp++;
      if ({obs, req_ready} !== {73'd0, 1'b1}) begin
         n_bad++;
         $display("FAIL reset_hold: got %h ready=%b, want 0 ready=1", obs, req_ready);
      end
      @(posedge clk); #2;
      reset = 1'b0;
      tick();
      n_cmp++;
      if ({obs, req_ready} !== {73'd0, 1'b1}) begin
         n_bad++;
         $display("FAIL reset_release: got %h ready=%b, want 0 ready=1", obs, req_ready);
      end
   endtask

   task automatic test_basic();
      logic [PL-1:0] pay = rand_payload();
      logic [72:0]   e;
      req_valid = 1'b1; req_addr = 12'hABC; req_len = 16'd100; req_payload = pay;
      tx_space = 6'd63;
      tick();
      req_valid = 1'b0;
      n_cmp++;
      if ({obs, req_ready} !== {73'd0, 1'b0}) begin
         n_bad++;
         $display("FAIL basic_accept: got %h ready=%b, want 0 ready=0", obs, req_ready);
      end
      tick();
      e = {3'b100, 6'd28, 64'h0064ABC000000000};
      n_cmp++;
      if (obs !== e) begin n_bad++; $display("FAIL basic_hdr: got %h want %h", obs, e); end
      tick();
      e = {3'b100, 6'd63, pay[99:37], 1'b0};
      n_cmp++;
      if (obs !== e) begin n_bad++; $display("FAIL basic_chunk1: got %h want %h", obs, e); end
      tick();
      e = {3'b110, 6'd37, pay[36:0], 27'd0};
      n_cmp++;
      if ({obs, req_ready} !== {e, 1'b1}) begin
         n_bad++;
         $display("FAIL basic_chunk2: got %h ready=%b want %h ready=1", obs, req_ready, e);
      end
      tick();
      n_cmp++;
      if (obs !== 73'd0) begin n_bad++; $display("FAIL basic_after: got %h want 0", obs); end
   endtask

   task automatic test_hdr_wait();
      logic [PL-1:0] pay = rand_payload();
      logic [72:0]   e;
      req_valid = 1'b1; req_addr = 12'h123; req_len = 16'd40; req_payload = pay;
      tx_space = 6'd20;
      tick();
      req_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         n_cmp++;
         if (rresp_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL hdr_wait_skip%0d: rresp_valid=%b want 0", i, rresp_valid);
         end
      end
      tx_space = 6'd30;
      tick();
      e = {3'b100, 6'd28, 16'd40, 12'h123, 36'd0};
      n_cmp++;
      if (obs !== e) begin n_bad++; $display("FAIL hdr_wait_hdr: got %h want %h", obs, e); end
      tx_space = 6'd63;
      tick();
      e = {3'b110, 6'd40, pay[39:0], 24'd0};
      n_cmp++;
      if (obs !== e) begin n_bad++; $display("FAIL hdr_wait_data: got %h want %h", obs, e); end
      tick();
   endtask

   task automatic test_err();
      logic [HW-1:0] lens [2] = '{16'd0, 16'd513};
      tx_space = 6'd63;
      for (int i = 0; i < 2; i++) begin
         req_valid = 1'b1; req_len = lens[i]; req_payload = rand_payload();
         tick();
         req_valid = 1'b0;
         n_cmp++;
         if ({req_err, rresp_valid, req_ready} !== 3'b101) begin
            n_bad++;
            $display("FAIL err_pulse len=%0d: err/valid/ready=%b want 101", lens[i],
                     {req_err, rresp_valid, req_ready});
         end
         for (int j = 0; j < 3; j++) begin
            tick();
            n_cmp++;
            if ({obs, req_ready} !== {73'd0, 1'b1}) begin
               n_bad++;
               $display("FAIL err_quiet len=%0d: got %h ready=%b want 0 ready=1",
                        lens[i], obs, req_ready);
            end
         end
      end
   endtask

   task automatic test_small_slots();
      logic [5:0]  sp [4] = '{6'd63, 6'd0, 6'd5, 6'd63};
      logic [72:0] e [4];
      e[0] = {3'b100, 6'd28, 16'd8, 12'h055, 36'd0};
      e[1] = 73'd0;
      e[2] = {3'b100, 6'd5, 64'hA000000000000000};
      e[3] = {3'b110, 6'd3, 64'hA000000000000000};
      req_valid = 1'b1; req_addr = 12'h055; req_len = 16'd8;
      req_payload = '0; req_payload[7:0] = 8'hA5;
      tick();
      req_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tx_space = sp[i];
         tick();
         n_cmp++;
         if (obs !== e[i]) begin
            n_bad++;
            $display("FAIL small_slot%0d: got %h want %h", i, obs, e[i]);
         end
      end
      tick();
   endtask

   task automatic test_reset_mid();
      logic [PL-1:0] pay = rand_payload();
      logic [72:0]   e;
      req_valid = 1'b1; req_addr = 12'h777; req_len = 16'd150; req_payload = pay;
      tx_space = 6'd63;
      tick();
      req_valid = 1'b0;
      tick();
      tick();
      e = {3'b100, 6'd63, exp_chunk(pay, 150, 0, 63)};
      n_cmp++;
      if (obs !== e) begin n_bad++; $display("FAIL rst_mid_chunk1: got %h want %h", obs, e); end
      #2 reset = 1'b1;
      #1;
      n_cmp++;
      if ({obs, req_ready} !== {73'd0, 1'b1}) begin
         n_bad++;
         $display("FAIL rst_mid_async: got %h ready=%b want 0 ready=1", obs, req_ready);
      end
      tick();
      reset = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick();
         n_cmp++;
         if ({obs, req_ready} !== {73'd0, 1'b1}) begin
            n_bad++;
            $display("FAIL rst_mid_after%0d: got %h ready=%b want 0 ready=1", i, obs, req_ready);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [PL-1:0] pay [2];
      int            len [2];
      logic [AW-1:0] adr [2];
      int            done_cyc [2] = '{-1, -1};
      int            hdr_cyc  [2] = '{-1, -1};
      int            acc_cyc  [2] = '{-1, -1};
      int            n_acc = 0, msg = 0, cyc = 0, rx_len = 0, rx_got = 0;
      bit            in_msg = 0, acc;
      logic [PL-1:0] rx_buf = '0;
      for (int i = 0; i < 2; i++) begin
         pay[i] = rand_payload();
         len[i] = $urandom_range(1, PL);
         adr[i] = AW'($urandom);
      end
      tx_space = 6'd63;
      req_valid = 1'b1; req_addr = adr[0]; req_len = HW'(len[0]); req_payload = pay[0];
      while (msg < 2 && cyc < 200) begin
         acc = req_valid && req_ready;
         tick();
         cyc++;
         if (acc) begin
            acc_cyc[n_acc] = cyc;
            n_acc++;
            if (n_acc == 1) begin
               req_addr = adr[1]; req_len = HW'(len[1]); req_payload = pay[1];
            end else req_valid = 1'b0;
         end
         if (rresp_valid) begin
            if (!in_msg) begin
               n_cmp++;
               if ({tx_len, tx_ipg_data} !== {6'd28, HW'(len[msg]), adr[msg], 36'd0}) begin
                  n_bad++;
                  $display("FAIL b2b_hdr%0d: got len=%0d data=%h", msg, tx_len, tx_ipg_data);
               end
               rx_len = int'(tx_ipg_data[63:48]);
               rx_got = 0; rx_buf = '0; in_msg = 1; hdr_cyc[msg] = cyc;
            end else begin
               for (int k = 0; k < int'(tx_len); k++)
                  if (rx_len-1-rx_got-k >= 0) rx_buf[rx_len-1-rx_got-k] = tx_ipg_data[DW-1-k];
               rx_got += int'(tx_len);
               if (rx_got >= rx_len || done) begin
                  n_cmp++;
                  if ({done, rx_buf} !== {1'b1, pay[msg] & len_mask(len[msg])}) begin
                     n_bad++;
                     $display("FAIL b2b_payload%0d: done=%b got %h want %h", msg, done,
                              rx_buf[63:0], pay[msg][63:0]);
                  end
                  done_cyc[msg] = cyc; in_msg = 0; msg++;
               end
            end
         end
      end
      n_cmp++;
      if (msg != 2) begin
         n_bad++;
         $display("FAIL b2b_timeout: got %0d messages want 2", msg);
      end else begin
         n_cmp++;
         if ({acc_cyc[1], hdr_cyc[1]} !== {done_cyc[0] + 1, done_cyc[0] + 2}) begin
            n_bad++;
            $display("FAIL b2b_gap: accept=%0d hdr=%0d want %0d/%0d", acc_cyc[1], hdr_cyc[1],
                     done_cyc[0] + 1, done_cyc[0] + 2);
         end
      end
      tick();
   endtask

   task automatic test_random();
      localparam int N = 30;
      int            phase = 0;   // 0 waiting, 1 header owed, 2 payload owed
      int            m_len = 0, m_sent = 0, started = 0, finished = 0, cyc = 0, sp, n;
      logic [AW-1:0] m_addr = '0;
      logic [PL-1:0] m_pay = '0;
      bit            pending = 0, acc;
      logic [72:0]   e;
      while (finished < N && cyc < 30000) begin
         if (!pending && started < N && $urandom_range(0, 3) != 0) begin
            req_valid = 1'b1;
            req_addr = AW'($urandom);
            req_payload = rand_payload();
            if ($urandom_range(0, 9) == 0)
               req_len = $urandom_range(0, 1) ? 16'd0 : HW'($urandom_range(PL + 1, 65535));
            else
               req_len = HW'($urandom_range(1, PL));
            pending = 1; started++;
         end
         case ($urandom_range(0, 3))
            0:       sp = 0;
            1:       sp = $urandom_range(1, 27);
            2:       sp = $urandom_range(28, 40);
            default: sp = $urandom_range(41, 63);
         endcase
         tx_space = 6'(sp);
         n_cmp++;
         if (req_ready !== (phase == 0)) begin
            n_bad++;
            $display("FAIL rand_ready cyc%0d: got %b want %b", cyc, req_ready, phase == 0);
         end
         acc = req_valid && (phase == 0);
         tick();
         cyc++;
         e = '0;
         if (phase == 0) begin
            if (acc) begin
               m_len = int'(req_len); m_addr = req_addr; m_pay = req_payload;
               m_sent = 0; pending = 0;
               if (m_len == 0 || m_len > PL) begin
                  e[70] = 1'b1;
                  finished++;
               end else phase = 1;
               // later request-input changes must have no effect
               req_valid = 1'b0; req_addr = AW'($urandom); req_len = HW'($urandom);
               req_payload = rand_payload();
            end
         end else if (phase == 1) begin
            if (sp >= 28) begin
               e = {3'b100, 6'd28, HW'(m_len), m_addr, 36'd0};
               phase = 2;
            end
         end else if (sp > 0) begin
            n = (sp < m_len - m_sent) ? sp : m_len - m_sent;
            m_sent += n;
            e = {1'b1, m_sent == m_len, 1'b0, 6'(n), exp_chunk(m_pay, m_len, m_sent - n, n)};
            if (m_sent == m_len) begin
               phase = 0; finished++;
            end
         end
         n_cmp++;
         if (obs !== e) begin
            n_bad++;
            $display("FAIL rand_out cyc%0d sp=%0d: got %h want %h", cyc, sp, obs, e);
         end
      end
      n_cmp++;
      if (finished != N) begin
         n_bad++;
         $display("FAIL rand_timeout: finished %0d want %0d", finished, N);
      end
      idle_inputs();
      tick();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_hdr_wait();
      test_err();
      test_small_slots();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
